// File: rtl/mix_dose_sequencer_if.sv
// Control/status bundle of the mix-dose sequencer: run request, run configuration
// and the pneumatic air-line drives with run status pulses.
interface mix_dose_sequencer_if #(
  parameter int unsigned DWELL_W  = 16,
  parameter int unsigned STROKE_W = 8,
  parameter int unsigned INCUB_W  = 24
);
  logic                start;
  logic                abort;
  logic [DWELL_W-1:0]  dwell;
  logic [STROKE_W-1:0] strokes_a;
  logic [STROKE_W-1:0] strokes_b;
  logic [INCUB_W-1:0]  incub;
  logic                air_a;
  logic                air_b;
  logic [2:0]          air_pump;
  logic                air_drain;
  logic                busy;
  logic                done;
  logic                aborted;

  modport master (
    output start, abort, dwell, strokes_a, strokes_b, incub,
    input  air_a, air_b, air_pump, air_drain, busy, done, aborted
  );

  modport slave (
    input  start, abort, dwell, strokes_a, strokes_b, incub,
    output air_a, air_b, air_pump, air_drain, busy, done, aborted
  );
endinterface

// File: rtl/mix_dose_sequencer.sv
// Pneumatic sequencer: meters reagent A then B through a 3-valve peristaltic pump,
// incubates with every valve closed, then drains. Air line 1 = valve closed.
module mix_dose_sequencer #(
  parameter int unsigned DWELL_W  = 16,
  parameter int unsigned STROKE_W = 8,
  parameter int unsigned INCUB_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mix_dose_sequencer_if.slave   seq_io
);
  localparam int unsigned SUM_W   = STROKE_W + 1;
  localparam int unsigned PHASE_W = 3;

  typedef enum logic [2:0] {IDLE, FILL_A, FILL_B, INCUB, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [STROKE_W-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [INCUB_W-1:0]  incub_q, incub_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [DWELL_W-1:0]  dcnt_q, dcnt_d;
  logic [SUM_W-1:0]    scnt_q, scnt_d;
  logic [INCUB_W-1:0]  icnt_q, icnt_d;
  logic                air_a_q, air_a_d, air_b_q, air_b_d, air_drain_q, air_drain_d;
  logic [2:0]          air_pump_q, air_pump_d;
  logic                busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

  logic [DWELL_W-1:0]  dwell_last;
  logic [SUM_W-1:0]    stroke_target;
  logic                phase_end, stroke_end;

  // First state at or after 'from' whose work count is non-zero; empty states fall through.
  function automatic state_e first_from(state_e from, logic a_nz, logic b_nz, logic i_nz);
    state_e r;
    r = IDLE;
    if (from == FILL_A && a_nz)                           r = FILL_A;
    else if ((from == FILL_A || from == FILL_B) && b_nz)  r = FILL_B;
    else if (from != DRAIN && i_nz)                       r = INCUB;
    else if (a_nz || b_nz)                                r = DRAIN;
    return r;
  endfunction

  function automatic logic [2:0] pump_pattern(logic [PHASE_W-1:0] ph);
    logic [2:0] p;
    case (ph)
      3'd0:    p = 3'b011;
      3'd1:    p = 3'b001;
      3'd2:    p = 3'b101;
      3'd3:    p = 3'b100;
      3'd4:    p = 3'b110;
      3'd5:    p = 3'b010;
      default: p = 3'b111;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dwell_q     <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      incub_q     <= '0;
      phase_q     <= '0;
      dcnt_q      <= '0;
      scnt_q      <= '0;
      icnt_q      <= '0;
      air_a_q     <= 1'b1;
      air_b_q     <= 1'b1;
      air_drain_q <= 1'b1;
      air_pump_q  <= 3'b111;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      incub_q     <= incub_d;
      phase_q     <= phase_d;
      dcnt_q      <= dcnt_d;
      scnt_q      <= scnt_d;
      icnt_q      <= icnt_d;
      air_a_q     <= air_a_d;
      air_b_q     <= air_b_d;
      air_drain_q <= air_drain_d;
      air_pump_q  <= air_pump_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    incub_d   = incub_q;
    phase_d   = phase_q;
    dcnt_d    = dcnt_q;
    scnt_d    = scnt_q;
    icnt_d    = icnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
    phase_end  = (dcnt_q == dwell_last);
    stroke_end = phase_end && (phase_q == PHASE_W'(5));
    case (state_q)
      FILL_A:  stroke_target = SUM_W'(sa_q);
      FILL_B:  stroke_target = SUM_W'(sb_q);
      default: stroke_target = SUM_W'(sa_q) + SUM_W'(sb_q);
    endcase

    case (state_q)
      IDLE: begin
        if (seq_io.start && !seq_io.abort) begin
          dwell_d = seq_io.dwell;
          sa_d    = seq_io.strokes_a;
          sb_d    = seq_io.strokes_b;
          incub_d = seq_io.incub;
          state_d = first_from(FILL_A, |seq_io.strokes_a, |seq_io.strokes_b, |seq_io.incub);
          done_d  = (state_d == IDLE);
        end
      end
      FILL_A, FILL_B, DRAIN: begin
        dcnt_d = dcnt_q + DWELL_W'(1);
        if (phase_end) begin
          dcnt_d  = '0;
          phase_d = (phase_q == PHASE_W'(5)) ? '0 : phase_q + PHASE_W'(1);
        end
        if (stroke_end) begin
          scnt_d = scnt_q + SUM_W'(1);
          if (scnt_q == stroke_target - SUM_W'(1)) begin
            case (state_q)
              FILL_A:  state_d = first_from(FILL_B, |sa_q, |sb_q, |incub_q);
              FILL_B:  state_d = first_from(INCUB, |sa_q, |sb_q, |incub_q);
              default: state_d = IDLE;
            endcase
          end
        end
      end
      INCUB: begin
        icnt_d = icnt_q + INCUB_W'(1);
        if (icnt_q == incub_q - INCUB_W'(1)) begin
          state_d = first_from(DRAIN, |sa_q, |sb_q, |incub_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over a completion decided in the same cycle.
    if (state_q != IDLE && seq_io.abort) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else if (state_q != IDLE && state_d == IDLE) begin
      done_d = 1'b1;
    end

    if (state_d != state_q) begin
      phase_d = '0;
      dcnt_d  = '0;
      scnt_d  = '0;
      icnt_d  = '0;
    end

    air_a_d     = (state_d != FILL_A);
    air_b_d     = (state_d != FILL_B);
    air_drain_d = (state_d != DRAIN);
    air_pump_d  = (state_d == FILL_A || state_d == FILL_B || state_d == DRAIN)
                  ? pump_pattern(phase_d) : 3'b111;
    busy_d      = (state_d != IDLE);
  end

  assign seq_io.air_a     = air_a_q;
  assign seq_io.air_b     = air_b_q;
  assign seq_io.air_drain = air_drain_q;
  assign seq_io.air_pump  = air_pump_q;
  assign seq_io.busy      = busy_q;
  assign seq_io.done      = done_q;
  assign seq_io.aborted   = aborted_q;
endmodule

// File: tb/tb_mix_dose_sequencer.sv
// Scoreboard bench for mix_dose_sequencer: each run pushes its expected profile,
// a negedge monitor profiles the air lines and checks it on every done/aborted pulse.
module tb_mix_dose_sequencer;
  logic clk = 1'b0;
  logic rst_n;

  mix_dose_sequencer_if #(.DWELL_W(16), .STROKE_W(8), .INCUB_W(24)) bus ();

  mix_dose_sequencer #(.DWELL_W(16), .STROKE_W(8), .INCUB_W(24)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_io (bus.slave)
  );

  always #5 clk = ~clk;

  // code: 2'b10 done, 2'b01 aborted, 2'b00 run abandoned by reset (no pulse expected)
  typedef struct {
    logic [1:0] code;
    int         busy;
    int         a;
    int         b;
    int         d;
    int         cl;
    bit         trace;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         events_seen = 0;
  int         timeouts = 0;
  int         seen_timeouts = 0;
  bit         reset_chk_req = 1'b0;
  bit         end_req = 1'b0;
  int         m_busy = 0, m_a = 0, m_b = 0, m_d = 0, m_cl = 0;
  logic [2:0] m_trace [64];
  logic [2:0] pat6 [6];

  initial begin
    pat6[0] = 3'b011; pat6[1] = 3'b001; pat6[2] = 3'b101;
    pat6[3] = 3'b100; pat6[4] = 3'b110; pat6[5] = 3'b010;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: the only process that steps total/bad.
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] obs;
    int         tr_bad;
    if (timeouts != seen_timeouts) begin
      seen_timeouts = timeouts;
      total++;
      bad++;
      $display("FAIL timeout: wait for DUT event expired (count %0d)", timeouts);
    end
    if (!rst_n) begin
      if (reset_chk_req) begin
        obs = {bus.air_a, bus.air_b, bus.air_drain, bus.air_pump, bus.busy, bus.done, bus.aborted};
        chk("reset_outputs", int'(obs), int'(9'b111111000));
      end
      if (sb.size() > 0 && sb[0].code == 2'b00) void'(sb.pop_front());
      m_busy = 0; m_a = 0; m_b = 0; m_d = 0; m_cl = 0;
    end else begin
      if (bus.busy) begin
        if (m_busy == 0) chk("run_expected", sb.size() > 0 ? 1 : 0, 1);
        chk("invariant", ((!bus.air_a && !bus.air_b) ||
                          (!bus.air_drain && (!bus.air_a || !bus.air_b))) ? 1 : 0, 0);
        if (m_busy < 64) m_trace[m_busy] = bus.air_pump;
        m_busy++;
        if (!bus.air_a) m_a++;
        if (!bus.air_b) m_b++;
        if (!bus.air_drain) m_d++;
        if (bus.air_a && bus.air_b && bus.air_drain && bus.air_pump == 3'b111) m_cl++;
      end
      if (bus.done || bus.aborted) begin
        events_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("end_code", int'({bus.done, bus.aborted}), int'(e.code));
          chk("busy_cycles", m_busy, e.busy);
          chk("fill_a_cycles", m_a, e.a);
          chk("fill_b_cycles", m_b, e.b);
          chk("drain_cycles", m_d, e.d);
          chk("closed_cycles", m_cl, e.cl);
          if (e.trace) begin
            tr_bad = 0;
            for (int i = 0; i < 24; i++)
              if (m_trace[i] !== pat6[(i / 2) % 6]) tr_bad++;
            chk("pump_trace_errors", tr_bad, 0);
          end
        end
        m_busy = 0; m_a = 0; m_b = 0; m_d = 0; m_cl = 0;
      end
      if (end_req) begin
        chk("scoreboard_empty", sb.size(), 0);
      end
    end
  end

  task automatic push_exp(input logic [1:0] code, input int busy, input int a, input int b,
                          input int d, input int cl, input bit trace);
    exp_t e;
    e.code = code; e.busy = busy; e.a = a; e.b = b; e.d = d; e.cl = cl; e.trace = trace;
    sb.push_back(e);
  endtask

  task automatic do_start(input int dw, input int sa, input int sbk, input int inc);
    @(posedge clk);
    #1;
    bus.dwell     = 16'(dw);
    bus.strokes_a = 8'(sa);
    bus.strokes_b = 8'(sbk);
    bus.incub     = 24'(inc);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_event(input int budget);
    int prev;
    int n;
    prev = events_seen;
    n = 0;
    while (events_seen == prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (events_seen == prev) timeouts++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int k;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.dwell = '0; bus.strokes_a = '0; bus.strokes_b = '0; bus.incub = '0;
    reset_chk_req = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset_chk_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of DRAIN
    push_exp(2'b00, 0, 0, 0, 0, 0, 1'b0);
    do_start(1, 1, 0, 0);
    n = 0;
    while (bus.air_drain !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.air_drain !== 1'b0) timeouts++;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset_chk_req = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_chk_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // dwell=2, one A stroke, then one drain stroke
    push_exp(2'b10, 24, 12, 0, 12, 0, 1'b1);
    do_start(2, 1, 0, 0);
    wait_event(100);

    // dwell 0 acts as 1
    push_exp(2'b10, 41, 12, 6, 18, 5, 1'b0);
    do_start(0, 2, 1, 5);
    wait_event(100);

    // all counts zero: done only
    push_exp(2'b10, 0, 0, 0, 0, 0, 1'b0);
    do_start(0, 0, 0, 0);
    wait_event(5);

    // abort in third INCUB cycle, then restart
    push_exp(2'b01, 15, 6, 6, 0, 3, 1'b0);
    do_start(1, 1, 1, 10);
    n = 0; k = 0;
    while (k < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.busy && bus.air_a && bus.air_b && bus.air_drain && bus.air_pump == 3'b111) k++;
    end
    if (k < 3) timeouts++;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    wait_event(20);
    push_exp(2'b10, 38, 0, 18, 18, 2, 1'b0);
    do_start(3, 0, 1, 2);
    wait_event(100);

    // start and config changes mid-run are ignored
    push_exp(2'b10, 40, 6, 12, 18, 4, 1'b0);
    do_start(1, 1, 2, 4);
    n = 0;
    while (bus.air_b !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.air_b !== 1'b0) timeouts++;
    bus.start = 1'b1;
    bus.dwell = 16'd7; bus.strokes_a = 8'd3; bus.strokes_b = 8'd0; bus.incub = 24'd9;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_event(100);
    repeat (60) @(negedge clk);

    end_req = 1'b1;
    @(negedge clk);
    #1 end_req = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
